// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature paddle decoder: Gray-coded AB
// states, the INIT/RUN state enum, and the step classification function.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        FWD     = 2'd1,
        BWD     = 2'd2,
        ILLEGAL = 2'd3
    } step_e;

    // Position of an AB pair along the forward cycle 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            S00:     idx = 2'd0;
            S10:     idx = 2'd1;
            S11:     idx = 2'd2;
            S01:     idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] delta;
        step_e      step;
        delta = gray_idx(cur_ab) - gray_idx(prev_ab);
        case (delta)
            2'd0:    step = NONE;
            2'd1:    step = FWD;
            2'd3:    step = BWD;
            default: step = ILLEGAL;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a persistence filter
// that only accepts a new level after FILT_LEN consecutive disagreeing samples.
module quad_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    input  logic i_track,
    output logic o_filt
);

    logic       r_s1;
    logic       r_s2;
    logic       r_filt;
    logic [3:0] r_cnt;
    logic       w_filt_nxt;
    logic [3:0] w_cnt_nxt;

    // While tracking, the filtered level follows the synchronised input directly.
    always_comb begin
        w_filt_nxt = r_filt;
        w_cnt_nxt  = 4'd0;
        if (i_track) begin
            w_filt_nxt = r_s2;
        end else if (r_s2 != r_filt) begin
            if ((r_cnt + 4'd1) == 4'(FILT_LEN)) begin
                w_filt_nxt = ~r_filt;
                w_cnt_nxt  = 4'd0;
            end else begin
                w_cnt_nxt  = r_cnt + 4'd1;
            end
        end else begin
            w_cnt_nxt = 4'd0;
        end
    end

    // Synchroniser, filter counter and filtered level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_filt <= w_filt_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quad_paddle_decoder.sv
// Paddle quadrature front end: filtered channels feed a 4x decoder that drives
// a saturating position counter and a saturating illegal-transition counter.
module quad_paddle_decoder
    import quad_pkg::*;
#(
    parameter int POS_W    = 9,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 511,
    parameter int POS_INIT = 256,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             clear,
    output logic [POS_W-1:0] position,
    output logic             moved,
    output logic             dir,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam logic [POS_W-1:0] P_MIN     = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] P_MAX     = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT    = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] P_ONE     = POS_W'(1);
    localparam logic [4:0]       INIT_LAST = 5'(FILT_LEN + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [4:0]       r_init_cnt;
    logic [4:0]       w_init_cnt_nxt;
    logic [1:0]       r_prev;
    logic [1:0]       w_prev_nxt;
    logic [POS_W-1:0] r_position;
    logic [POS_W-1:0] w_pos_nxt;
    logic             r_moved;
    logic             w_moved_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [7:0]       r_err_count;
    logic [7:0]       w_errcnt_nxt;
    logic             w_filt_a;
    logic             w_filt_b;
    logic [1:0]       w_filt;
    logic             w_track;
    step_e            w_step;

    assign w_track = (r_state == INIT);
    assign w_filt  = {w_filt_a, w_filt_b};

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (quadA),
        .i_track (w_track),
        .o_filt  (w_filt_a)
    );

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (quadB),
        .i_track (w_track),
        .o_filt  (w_filt_b)
    );

    // Next-state logic: INIT settle timer, step decode, saturation, clear override.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_prev_nxt     = r_prev;
        w_pos_nxt      = r_position;
        w_moved_nxt    = 1'b0;
        w_dir_nxt      = r_dir;
        w_err_nxt      = 1'b0;
        w_errcnt_nxt   = r_err_count;
        w_step         = decode_step(r_prev, w_filt);
        case (r_state)
            INIT: begin
                // prev is seeded from the settled inputs so a resting non-00 encoder is not an error
                if (r_init_cnt == INIT_LAST) begin
                    w_prev_nxt     = w_filt;
                    w_state_nxt    = RUN;
                    w_init_cnt_nxt = 5'd0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 5'd1;
                end
            end
            RUN: begin
                w_prev_nxt = w_filt;
                case (w_step)
                    FWD: begin
                        w_dir_nxt = 1'b1;
                        if (r_position < P_MAX) begin
                            w_pos_nxt   = r_position + P_ONE;
                            w_moved_nxt = 1'b1;
                        end else begin
                            w_pos_nxt   = r_position;
                        end
                    end
                    BWD: begin
                        w_dir_nxt = 1'b0;
                        if (r_position > P_MIN) begin
                            w_pos_nxt   = r_position - P_ONE;
                            w_moved_nxt = 1'b1;
                        end else begin
                            w_pos_nxt   = r_position;
                        end
                    end
                    ILLEGAL: begin
                        w_err_nxt = 1'b1;
                        if (r_err_count != 8'hFF) begin
                            w_errcnt_nxt = r_err_count + 8'd1;
                        end else begin
                            w_errcnt_nxt = r_err_count;
                        end
                    end
                    default: begin
                        w_pos_nxt = r_position;
                    end
                endcase
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
        if (clear) begin
            w_pos_nxt    = P_INIT;
            w_errcnt_nxt = 8'd0;
            w_moved_nxt  = 1'b0;
            w_err_nxt    = 1'b0;
            w_dir_nxt    = r_dir;
        end else begin
            w_errcnt_nxt = w_errcnt_nxt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_init_cnt  <= 5'd0;
            r_prev      <= S00;
            r_position  <= P_INIT;
            r_moved     <= 1'b0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_prev      <= w_prev_nxt;
            r_position  <= w_pos_nxt;
            r_moved     <= w_moved_nxt;
            r_dir       <= w_dir_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_errcnt_nxt;
        end
    end

    assign position  = r_position;
    assign moved     = r_moved;
    assign dir       = r_dir;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// Self-checking bench for quad_paddle_decoder: table-driven step vectors plus
// hand-written corner sequences, with pulses checked against a scoreboard queue.
module tb_quad_paddle_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       quadA = 1'b0;
    logic       quadB = 1'b0;
    logic       clear = 1'b0;
    logic [8:0] position;
    logic       moved;
    logic       dir;
    logic       err;
    logic [7:0] err_count;

    typedef struct {
        logic [8:0] pos;
        logic       dir;
        logic       moved;
        logic       err;
        logic [7:0] ecnt;
        int         cyc;
    } rec_t;

    typedef struct {
        logic       fwd;
        logic [8:0] pos;
        logic       dir;
    } vec_t;

    rec_t sb[$];
    vec_t vt[32];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_moved = 0;
    int n_err = 0;
    int m_idx = 0;
    int m_pos = 256;
    int m_ecnt = 0;
    int mv0 = 0;
    int e0 = 0;
    bit m_dir = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    quad_paddle_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .quadA     (quadA),
        .quadB     (quadB),
        .clear     (clear),
        .position  (position),
        .moved     (moved),
        .dir       (dir),
        .err       (err),
        .err_count (err_count)
    );

    // Every moved/err pulse must match the oldest expected record, at its predicted cycle.
    always @(negedge clk) begin
        rec_t r;
        if (rst_n && (moved || err)) begin
            if (moved) n_moved = n_moved + 1;
            if (err) n_err = n_err + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: moved=%0b err=%0b pos=%0d cyc=%0d, required no pulse",
                         moved, err, position, cyc);
            end else begin
                r = sb.pop_front();
                if (position !== r.pos || dir !== r.dir || moved !== r.moved ||
                    err !== r.err || err_count !== r.ecnt || cyc != r.cyc) begin
                    errors = errors + 1;
                    $display("FAIL pulse: got pos=%0d dir=%0b moved=%0b err=%0b ecnt=%0d cyc=%0d, expected pos=%0d dir=%0b moved=%0b err=%0b ecnt=%0d cyc=%0d",
                             position, dir, moved, err, err_count, cyc,
                             r.pos, r.dir, r.moved, r.err, r.ecnt, r.cyc);
                end
            end
        end
    end

    function automatic logic [1:0] gray(input int idx);
        case (idx & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int idx);
        m_idx = idx & 3;
        {quadA, quadB} = gray(m_idx);
    endtask

    task automatic push(input logic mv, input logic er);
        rec_t r;
        r.pos = 9'(m_pos);
        r.dir = m_dir;
        r.moved = mv;
        r.err = er;
        r.ecnt = 8'(m_ecnt);
        r.cyc = cyc + 7;
        sb.push_back(r);
    endtask

    task automatic step(input bit fwd, input int hold);
        if (fwd) begin
            m_dir = 1'b1;
            if (m_pos < 511) begin
                m_pos = m_pos + 1;
                push(1'b1, 1'b0);
            end
        end else begin
            m_dir = 1'b0;
            if (m_pos > 0) begin
                m_pos = m_pos - 1;
                push(1'b1, 1'b0);
            end
        end
        drive(fwd ? m_idx + 1 : m_idx + 3);
        repeat (hold) @(negedge clk);
    endtask

    task automatic illegal(input int hold);
        if (m_ecnt < 255) m_ecnt = m_ecnt + 1;
        push(1'b0, 1'b1);
        drive(m_idx + 2);
        repeat (hold) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            vt[i].fwd = (i < 16);
            vt[i].pos = (i < 16) ? 9'(257 + i) : 9'(271 - (i - 16));
            vt[i].dir = (i < 16);
        end

        quadA = 1'b1;
        quadB = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_position", position, 256);
        check("reset_moved", moved, 0);
        check("reset_err", err, 0);
        check("reset_err_count", err_count, 0);
        check("reset_dir", dir, 0);
        rst_n = 1'b1;
        m_idx = 2;
        repeat (20) @(negedge clk);
        check("init_position", position, 256);
        check("init_err_count", err_count, 0);
        check("init_no_moved", n_moved, 0);
        check("init_no_err", n_err, 0);

        for (int i = 0; i < 32; i++) begin
            rec_t r;
            r.pos = vt[i].pos;
            r.dir = vt[i].dir;
            r.moved = 1'b1;
            r.err = 1'b0;
            r.ecnt = 8'(m_ecnt);
            r.cyc = cyc + 7;
            sb.push_back(r);
            drive(vt[i].fwd ? m_idx + 1 : m_idx + 3);
            m_pos = vt[i].pos;
            m_dir = vt[i].dir;
            repeat (10) @(negedge clk);
            if (i == 15) begin
                check("fwd16_position", position, 272);
                check("fwd16_dir", dir, 1);
                check("fwd16_moved_pulses", n_moved, 16);
            end
        end
        drain();
        check("bwd16_position", position, 256);
        check("bwd16_dir", dir, 0);
        check("bwd16_moved_pulses", n_moved, 32);

        quadA = ~quadA;
        repeat (3) @(negedge clk);
        quadA = ~quadA;
        repeat (15) @(negedge clk);
        check("glitch_position", position, 256);
        check("glitch_no_err", n_err, 0);
        check("glitch_no_moved", n_moved, 32);

        while (m_pos < 510) step(1'b1, 6);
        drain();
        check("near_max_position", position, 510);
        mv0 = n_moved;
        repeat (5) step(1'b1, 6);
        drain();
        check("sat_max_position", position, 511);
        check("sat_max_one_moved", n_moved - mv0, 1);
        check("sat_max_dir", dir, 1);

        while (m_pos > 1) step(1'b0, 6);
        drain();
        mv0 = n_moved;
        repeat (5) step(1'b0, 6);
        drain();
        check("sat_min_position", position, 0);
        check("sat_min_one_moved", n_moved - mv0, 1);
        check("sat_min_dir", dir, 0);

        e0 = n_err;
        illegal(10);
        drain();
        check("illegal_err_count", err_count, 1);
        check("illegal_position", position, 0);
        check("illegal_one_err", n_err - e0, 1);
        repeat (299) illegal(6);
        drain();
        check("illegal_sat_err_count", err_count, 255);

        drive(m_idx + 1);
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_position", position, 256);
        check("clear_err_count", err_count, 0);
        check("clear_no_moved", moved, 0);
        m_pos = 256;
        m_ecnt = 0;
        step(1'b1, 10);
        drain();
        check("post_clear_position", position, 257);
        check("post_clear_dir", dir, 1);

        illegal(10);
        drain();
        step(1'b1, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_position", position, 256);
        check("midreset_moved", moved, 0);
        check("midreset_err", err, 0);
        check("midreset_err_count", err_count, 0);
        check("midreset_dir", dir, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pos = 256;
        m_dir = 1'b0;
        m_ecnt = 0;
        repeat (20) @(negedge clk);
        step(1'b1, 10);
        drain();
        check("post_reset_position", position, 257);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_paddle_decoder.md
# quad_paddle_decoder

Quadrature front end for the paddle control. It synchronises and glitch-filters the raw encoder channels `quadA`/`quadB`, decodes 4x quadrature transitions, and maintains a saturating paddle position. It sits directly upstream of the game/video logic, which reads `position` as the paddle's horizontal offset. It also flags illegal (double-bit) transitions so encoder wiring or noise problems are visible.

## Interface
Parameters:
- `POS_W`, 9: position width in bits.
- `POS_MIN`, 0: lower saturation bound.
- `POS_MAX`, 511: upper saturation bound; must satisfy POS_MIN < POS_MAX < 2^POS_W.
- `POS_INIT`, 256: position value loaded on reset and on `clear`.
- `FILT_LEN`, 4: consecutive cycles a channel must differ from its filtered value before the filtered value flips; range 1..15.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `quadA`, in, 1: raw encoder channel A, asynchronous to `clk`.
- `quadB`, in, 1: raw encoder channel B, asynchronous to `clk`.
- `clear`, in, 1: synchronous request that reloads `position` to POS_INIT and zeroes `err_count`.
- `position`, out, POS_W: current paddle position.
- `moved`, out, 1: one-cycle pulse when `position` changed this cycle.
- `dir`, out, 1: direction of the last legal transition; 1 = forward (increment).
- `err`, out, 1: one-cycle pulse on an illegal transition.
- `err_count`, out, 8: count of illegal transitions, saturating at 255.

## Operation
- Sync: two flops per channel (s1, s2). These are reset to 0.
- Filter: per channel, a 4-bit counter.
  - When s2 != filt, the counter increments. When s2 == filt, it clears.
  - When the counter reaches FILT_LEN, filt toggles and the counter clears.
- FSM with two states: INIT and RUN.
  - INIT (entered on reset):
    - filt tracks s2 directly and the decoder is disabled.
    - After FILT_LEN+2 cycles, prev is loaded from filt and the FSM moves to RUN.
    - This prevents spurious errors when the encoder rests at a non-00 state.
  - RUN: each cycle, compare prev AB with filt AB, then set prev <= filt.
    - Forward sequence: 00->10->11->01->00. The reverse order is backward.
    - Legal forward step: `dir` <= 1. If position < POS_MAX, position +1 and `moved` pulses. Otherwise hold with no `moved`.
    - Legal backward step: `dir` <= 0. If position > POS_MIN, position -1 and `moved` pulses.
    - Both bits changed (illegal): position and `dir` are unchanged, `err` pulses, and `err_count` +1 unless already 255.
    - No change: nothing happens.
- `clear` has priority over any same-cycle transition.
  - Effects: position <= POS_INIT, err_count <= 0, `moved` = 0, `err` = 0.
  - prev still updates and FSM state is unaffected.
- Arithmetic is unsigned POS_W bits. Saturation means the counter never wraps.

## Timing
- Reset values:
  - `position` = POS_INIT
  - `moved` = 0, `err` = 0, `err_count` = 0, `dir` = 0
  - FSM = INIT, all sync, filter and prev flops = 0
- Reset is asynchronous on assertion. Deassertion must be synchronous to `clk` externally.
- Reset mid-movement: all outputs take their reset values immediately.
- Latency in RUN: a raw level change held stable is seen on edge 1 by s1 and edge 2 by s2.
  - filt flips on edge 2+FILT_LEN.
  - `position`/`moved`/`err` update on edge 3+FILT_LEN, which is 7 edges for the default.
- Pulses shorter than FILT_LEN cycles after sync are rejected entirely.
- Both filters flipping on the same edge counts as an illegal transition.
- Max legal step rate: one step per FILT_LEN+1 cycles per channel.
- Outputs are registered, with no combinational path from inputs.

## Structure
- Package `quad_pkg`:
  - constants for the AB Gray states (S00, S10, S11, S01)
  - FSM state enum (INIT, RUN)
  - step-decode function returning {NONE, FWD, BWD, ILLEGAL}
- Sub-module `quad_glitch_filter` (sync + FILT_LEN filter, one channel), instantiated twice.
- The top holds the FSM, decoder, position saturation and error counter.

## Test plan
- Reset release with inputs held AB=11 -> after INIT: no `err`, `err_count`=0, `position`=256, no `moved` pulses.
- 4 full forward cycles (16 steps), each phase held 10 cycles -> `position`=272, `dir`=1, 16 `moved` pulses, each 7 edges after its input change; then 16 backward steps -> `position`=256, `dir`=0.
- A pulsed high for 3 cycles (FILT_LEN=4) -> no filt change, `position` unchanged, no `err`.
- Start at `position`=510 and drive 5 forward steps -> `position`=511, exactly one `moved` pulse, `dir`=1; mirror case at POS_MIN holds at 0.
- Jump 00->11 held stable -> one `err` pulse, `err_count`=1, `position` unchanged; repeat 300 illegal jumps -> `err_count`=255.
- `clear` on the same edge as a legal forward step -> `position`=256, `err_count`=0, no `moved`; `rst_n` low mid-sequence -> outputs at reset values within the same cycle.
